// File: rtl/bnn_weight_streamer.sv
// bnn_weight_streamer
// Transmit side of the BNN nibble-serial weight-load interface. Host words are
// buffered in a small FIFO and serialised as two load_en beats each (low nibble
// first). The block counts completed words and raises done after NUM_NEURONS words.
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   ena_i          global enable; low freezes the FSM and inhibits pops
//   restart_i      one-cycle pulse: abort transfer, flush FIFO, clear count
//   wr_valid_i     host word valid
//   wr_data_i      host weight word
//   wr_ready_o     FIFO not full and not done
//   load_nibble_o  registered nibble beat to the core
//   load_en_o      registered beat enable (LO/HI states)
//   neuron_idx_o   registered count of completed words
//   busy_o         registered, high while streaming a word
//   done_o         registered, high once all words have been sent
module bnn_weight_streamer #(
    parameter int unsigned NUM_NEURONS = 20,
    parameter int unsigned FIFO_DEPTH  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena_i,
    input  logic       restart_i,
    input  logic       wr_valid_i,
    input  logic [7:0] wr_data_i,
    output logic       wr_ready_o,
    output logic [3:0] load_nibble_o,
    output logic       load_en_o,
    output logic [4:0] neuron_idx_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [4:0]      LastIdx = 5'(NUM_NEURONS);
    localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

    state_e          state_q;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [3:0]      nibble_q;
    logic            load_en_q;
    logic            busy_q;
    logic            done_q;
    logic [4:0]      idx_q;

    logic       wr_ready;
    logic       push;
    logic       pop;
    logic       flush;
    logic       last_word;
    logic       has_next;
    logic [7:0] head;
    logic [7:0] next_word;
    logic [4:0] idx_inc;

    always_comb begin
        // A same-cycle pop is deliberately ignored so a push never lands on a full FIFO.
        wr_ready  = (count_q != FullCnt) && (state_q != StDone);
        push      = wr_valid_i && wr_ready && !restart_i;
        pop       = (state_q == StHi) && ena_i && !restart_i;
        idx_inc   = idx_q + 5'd1;
        last_word = (idx_inc == LastIdx);
        // Finishing the last word discards anything queued behind it.
        flush     = restart_i || (pop && last_word);
        head      = mem_q[rd_ptr_q];
        // Follow-on word: already queued, or arriving this cycle into a one-entry FIFO.
        has_next  = (count_q >= CntW'(2)) || ((count_q == CntW'(1)) && push);
        next_word = (count_q >= CntW'(2)) ? mem_q[rd_ptr_q + PtrW'(1)] : wr_data_i;
    end

    // Storage is not reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            nibble_q  <= 4'h0;
            load_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            idx_q     <= 5'd0;
        end else if (restart_i) begin
            state_q   <= StIdle;
            nibble_q  <= 4'h0;
            load_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            idx_q     <= 5'd0;
        end else if (ena_i) begin
            unique case (state_q)
                StIdle: begin
                    if (count_q != '0) begin
                        state_q   <= StLo;
                        nibble_q  <= head[3:0];
                        load_en_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                StLo: begin
                    state_q  <= StHi;
                    nibble_q <= head[7:4];
                end
                StHi: begin
                    idx_q <= idx_inc;
                    if (last_word) begin
                        state_q   <= StDone;
                        nibble_q  <= 4'h0;
                        load_en_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end else if (has_next) begin
                        state_q  <= StLo;
                        nibble_q <= next_word[3:0];
                    end else begin
                        state_q   <= StIdle;
                        nibble_q  <= 4'h0;
                        load_en_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end
                end
                StDone: begin
                    state_q <= StDone;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign wr_ready_o    = wr_ready;
    assign load_nibble_o = nibble_q;
    assign load_en_o     = load_en_q;
    assign neuron_idx_o  = idx_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule
